// File: rtl/instr_mem_loader_if.sv
// Write-stream and fetch bus between a program source / core fetch stage and instr_mem_loader.
// The master side drives writes and fetch requests; the slave (loader) returns fetched words.
interface instr_mem_loader_if;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        fetch_en;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_data;
    logic        fetch_valid;

    modport master (
        output wr_en, wr_addr, wr_data, fetch_en, fetch_addr,
        input  fetch_data, fetch_valid
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, fetch_en, fetch_addr,
        output fetch_data, fetch_valid
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Captures a program into word-addressed instruction memory, holds the core in reset while loading,
// then serves 1-cycle fetches. Define INSTR_LOADER_CHECKSUM_EN to add the VERIFY checksum sweep.
module instr_mem_loader #(
    parameter int          DEPTH_LOG2   = 10,
    parameter logic [31:0] HALT_INSTR   = 32'h000fd073,
    parameter int          IDLE_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    instr_mem_loader_if.slave     bus,
    output logic                  core_rst,
    output logic                  load_done,
    output logic                  load_err,
    output logic [DEPTH_LOG2:0]   prog_len,
    output logic [31:0]           checksum
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = $clog2(IDLE_TIMEOUT + 1);

    typedef logic [DEPTH_LOG2:0] len_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
`ifdef INSTR_LOADER_CHECKSUM_EN
        S_VERIFY,
`endif
        S_RUN,
        S_ERROR
    } state_e;

    logic [31:0] mem [DEPTH];

    state_e            state_q, state_d;
    logic              halt_seen_q, halt_seen_d;
    len_t              prog_len_q, prog_len_d;
    logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic [31:0]       fetch_data_q, fetch_data_d;
    logic              fetch_valid_q, fetch_valid_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
    len_t              verify_idx_q, verify_idx_d;
    logic [31:0]       checksum_q, checksum_d;
`endif

    logic                  mem_we;
    logic                  wr_legal;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic [DEPTH_LOG2-1:0] fetch_idx;
    len_t                  wr_len;
    logic                  fetch_in_range;

    assign wr_idx   = bus.wr_addr[DEPTH_LOG2+1:2];
    assign wr_legal = (bus.wr_addr[1:0] == 2'b00) && (bus.wr_addr[31:DEPTH_LOG2+2] == '0);
    assign wr_len   = {1'b0, wr_idx} + len_t'(1);

    // Range check uses the full word index so high address bits cannot alias into the program.
    assign fetch_idx      = bus.fetch_addr[DEPTH_LOG2+1:2];
    assign fetch_in_range = {2'b00, bus.fetch_addr[31:2]} < {{(31-DEPTH_LOG2){1'b0}}, prog_len_q};

    always_comb begin
        state_d       = state_q;
        halt_seen_d   = halt_seen_q;
        prog_len_d    = prog_len_q;
        idle_cnt_d    = idle_cnt_q;
        mem_we        = 1'b0;
        fetch_valid_d = 1'b0;
        fetch_data_d  = '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
        verify_idx_d  = verify_idx_q;
        checksum_d    = checksum_q;
`endif
        case (state_q)
            S_IDLE, S_LOAD: begin
                if (bus.wr_en) begin
                    idle_cnt_d = '0;
                    if (wr_legal) begin
                        mem_we  = 1'b1;
                        state_d = S_LOAD;
                        if (wr_len > prog_len_q) prog_len_d = wr_len;
                        if (bus.wr_data == HALT_INSTR) halt_seen_d = 1'b1;
                    end else begin
                        state_d = S_ERROR;
                    end
                end else if (state_q == S_LOAD) begin
                    idle_cnt_d = idle_cnt_q + CNT_W'(1);
                    if (idle_cnt_d == CNT_W'(IDLE_TIMEOUT)) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
                        state_d = halt_seen_q ? S_VERIFY : S_ERROR;
`else
                        state_d = halt_seen_q ? S_RUN : S_ERROR;
`endif
                    end
                end
            end
`ifdef INSTR_LOADER_CHECKSUM_EN
            // One word per cycle, then a final cycle to hand over to RUN.
            S_VERIFY: begin
                if (verify_idx_q < prog_len_q) begin
                    checksum_d   = checksum_q + mem[verify_idx_q[DEPTH_LOG2-1:0]];
                    verify_idx_d = verify_idx_q + len_t'(1);
                end else begin
                    state_d = S_RUN;
                end
            end
`endif
            S_RUN: begin
                fetch_valid_d = bus.fetch_en;
                if (bus.fetch_en && fetch_in_range) fetch_data_d = mem[fetch_idx];
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            halt_seen_q   <= 1'b0;
            prog_len_q    <= '0;
            idle_cnt_q    <= '0;
            fetch_data_q  <= '0;
            fetch_valid_q <= 1'b0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            verify_idx_q  <= '0;
            checksum_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            halt_seen_q   <= halt_seen_d;
            prog_len_q    <= prog_len_d;
            idle_cnt_q    <= idle_cnt_d;
            fetch_data_q  <= fetch_data_d;
            fetch_valid_q <= fetch_valid_d;
`ifdef INSTR_LOADER_CHECKSUM_EN
            verify_idx_q  <= verify_idx_d;
            checksum_q    <= checksum_d;
`endif
        end
    end

    // Memory is deliberately left out of reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_idx] <= bus.wr_data;
    end

    assign core_rst        = (state_q != S_RUN);
    assign load_done       = (state_q == S_RUN);
    assign load_err        = (state_q == S_ERROR);
    assign prog_len        = prog_len_q;
    assign bus.fetch_data  = fetch_data_q;
    assign bus.fetch_valid = fetch_valid_q;
`ifdef INSTR_LOADER_CHECKSUM_EN
    assign checksum        = checksum_q;
`else
    assign checksum        = '0;
`endif
endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Receiving end of the instruction-write stream that `wr_en`/`wr_addr`/`wr_data` generators drive. The block captures program words into an internal word-addressed instruction memory and holds the core in reset while loading. It detects program end from the halt instruction plus bus idleness, then releases the core and serves 1-cycle-latency instruction fetches. It sits between the program source (generator or UART loader) and the core's fetch stage.

## Interface

- `DEPTH_LOG2`, 10, log2 of memory depth in 32-bit words.
- `HALT_INSTR`, 32'h000fd073, word that marks end of program.
- `IDLE_TIMEOUT`, 16, consecutive `wr_en`-low cycles that close the load window (≥2).
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  write strobe from program source.
- `wr_addr`  in  32  byte address of the word.
- `wr_data`  in  32  instruction word.
- `fetch_en`  in  1  fetch request from core.
- `fetch_addr`  in  32  byte address to fetch.
- `fetch_data`  out  32  fetched word, registered.
- `fetch_valid`  out  1  `fetch_data` valid this cycle.
- `core_rst`  out  1  active-high reset to core.
- `load_done`  out  1  program loaded, core running.
- `load_err`  out  1  sticky load error.
- `prog_len`  out  DEPTH_LOG2+1  program length in words.
- `checksum`  out  32  program checksum (see Configuration).

## Operation

- States: IDLE, LOAD, VERIFY (macro only), RUN, ERROR.
- IDLE: waits for a write. A write with `wr_en`=1 moves to LOAD and is itself committed.
- Write commit, in IDLE or LOAD:
  - Legal write: `wr_addr[1:0]`==0 and `wr_addr>>2` < 2^DEPTH_LOG2. It writes `mem[wr_addr>>2]`.
  - `prog_len` := max(`prog_len`, (`wr_addr>>2`)+1).
  - `wr_data`==HALT_INSTR sets internal `halt_seen`.
  - Repeated writes to the same address are legal; the last one wins.
- Illegal write (misaligned or out of range) → ERROR. The write is not committed.
- LOAD idle counter:
  - Increments each `wr_en`=0 cycle and clears on any `wr_en`=1.
  - At IDLE_TIMEOUT: if `halt_seen`, go to VERIFY (macro) or RUN; otherwise go to ERROR.
- RUN:
  - `core_rst`=0, `load_done`=1.
  - Writes are ignored; memory and `prog_len` are frozen.
- Fetch:
  - Honoured only in RUN.
  - Index is `fetch_addr>>2`; bits [1:0] are ignored.
  - Index ≥ `prog_len` returns 32'h0.
  - `fetch_en` outside RUN yields `fetch_valid`=0.
- ERROR: `load_err`=1, `core_rst`=1. Only `rst` exits.
- `core_rst`=1 in every state except RUN.

## Timing

- Reset values:
  - `core_rst`=1; `load_done`=0; `load_err`=0; `prog_len`=0.
  - `fetch_data`=0; `fetch_valid`=0; `checksum`=0.
  - State=IDLE; `halt_seen`=0; counters=0.
  - Memory contents are not cleared.
- Write: committed at the rising edge where `wr_en`=1. Readable by fetch from the next cycle.
- Fetch latency: 1 cycle. `fetch_en` sampled at edge N gives `fetch_data`/`fetch_valid` after edge N; back-to-back fetches every cycle are supported.
- LOAD→RUN, without macro: `core_rst` falls on the edge at which the idle counter reaches IDLE_TIMEOUT.
- LOAD→RUN, with macro: VERIFY takes `prog_len` cycles, then one cycle to RUN.
- `rst` has priority in every state, including mid-LOAD and mid-VERIFY. It returns the block to reset values.
- A write in the same cycle the counter would expire clears the counter; no transition happens.

## Configuration

- `INSTR_LOADER_CHECKSUM_EN` defined:
  - LOAD exit enters VERIFY, which sweeps `mem[0..prog_len-1]`, one word per cycle.
  - `checksum` := 32-bit wrapping sum of those words, valid when RUN is entered.
  - `fetch_en` during VERIFY is ignored.
- Not defined:
  - No VERIFY state; LOAD exits straight to RUN.
  - `checksum` is tied to 0.

## Test plan

- Load 30-word program, each address written 4 consecutive cycles, word 29 = 32'h000fd073, then `wr_en` low.
  - `core_rst` falls exactly 16 cycles after the last write (+31 with macro).
  - `prog_len`=30, `load_done`=1.
- RUN fetch of `fetch_addr`=8 returns word 2 next cycle with `fetch_valid`=1. `fetch_addr`=200 returns 32'h0.
- Write `wr_addr`=6 during LOAD → `load_err`=1 next cycle, `core_rst` stays 1. Address 4096 (DEPTH_LOG2=10) also → ERROR.
- Load 5 words without HALT_INSTR, then idle 16 cycles → ERROR, `load_done`=0.
- Assert `rst` after 10 words are loaded → reset values restored. A full reload then reaches RUN normally.
- With macro: words 1,2,3 plus halt → `checksum`=6+32'h000fd073. In RUN, write address 0 with 32'hffffffff → fetch 0 still returns the original word.
